// File: rtl/insencoder_pkg.sv
// Shared MIPS field widths, format codes, NOP word and encoder state type.
// ST_PAD exists only when INSENC_NOP_PAD_EN is defined.
package mips_pkg;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SA_W    = 5;
    localparam int FUNC_W  = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int INSTR_W = 32;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_BAD = 2'b11;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VALID,
`ifdef INSENC_NOP_PAD_EN
        ST_PAD,
`endif
        ST_DONE
    } state_t;
endpackage

// File: rtl/insencoder_if.sv
// Field-tuple input and instruction-word output handshakes of the encoder.
// master = tuple producer / word consumer, slave = encoder.
interface insencoder_if;
    import mips_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          fmt;
    logic [OP_W-1:0]     op;
    logic [REG_W-1:0]    rs, rt, rd;
    logic [SA_W-1:0]     sa;
    logic [FUNC_W-1:0]   func;
    logic [IMM_W-1:0]    immediate;
    logic [TGT_W-1:0]    target;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [31:0]         out_addr;

    modport master (output in_valid, fmt, op, rs, rt, rd, sa, func, immediate, target, out_ready,
                    input  in_ready, out_valid, out_instr, out_addr);
    modport slave  (input  in_valid, fmt, op, rs, rt, rd, sa, func, immediate, target, out_ready,
                    output in_ready, out_valid, out_instr, out_addr);
endinterface

// File: rtl/insencoder_pack.sv
// Combinational R/I/J field packer: fields + fmt -> 32-bit word, plus illegal-format flag.
module insfield_pack
    import mips_pkg::*;
(
    input  logic [1:0]         i_fmt,
    input  logic [OP_W-1:0]    i_op,
    input  logic [REG_W-1:0]   i_rs,
    input  logic [REG_W-1:0]   i_rt,
    input  logic [REG_W-1:0]   i_rd,
    input  logic [SA_W-1:0]    i_sa,
    input  logic [FUNC_W-1:0]  i_func,
    input  logic [IMM_W-1:0]   i_imm,
    input  logic [TGT_W-1:0]   i_target,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_bad
);
    always_comb begin
        o_word = NOP;
        o_bad  = 1'b0;
        case (i_fmt)
            FMT_R:   o_word = {i_op, i_rs, i_rt, i_rd, i_sa, i_func};
            FMT_I:   o_word = {i_op, i_rs, i_rt, i_imm};
            FMT_J:   o_word = {i_op, i_target};
            default: o_bad  = 1'b1;
        endcase
    end
endmodule

// File: rtl/insencoder.sv
// Packs MIPS field tuples into words streamed with imem byte addresses, bounded by DEPTH.
// Optional INSENC_NOP_PAD_EN: flush pads the remaining capacity with NOP words.
module insencoder
    import mips_pkg::*;
#(
    parameter  int          DEPTH     = 64,
    parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int          CW        = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                flush,
    insencoder_if.slave         bus,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                err,
    output logic                done
);
    state_t             r_state;
    logic               r_out_valid, r_full, r_err, r_done;
    logic [INSTR_W-1:0] r_out_instr;
    logic [31:0]        r_out_addr;
    logic [CW-1:0]      r_count;

    logic [INSTR_W-1:0] w_word, w_load_word;
    logic [31:0]        w_addr;
    logic [CW-1:0]      w_count_nx;
    logic               w_bad, w_accept, w_drain, w_load;
    logic               w_in_pad, w_pad_go, w_pad_load;

    insfield_pack u_pack (
        .i_fmt(bus.fmt), .i_op(bus.op), .i_rs(bus.rs), .i_rt(bus.rt), .i_rd(bus.rd),
        .i_sa(bus.sa), .i_func(bus.func), .i_imm(bus.immediate), .i_target(bus.target),
        .o_word(w_word), .o_bad(w_bad)
    );

`ifdef INSENC_NOP_PAD_EN
    localparam state_t ST_PAD_TGT = ST_PAD;
    logic r_flush_pend;

    assign w_in_pad   = (r_state == ST_PAD);
    // A flush seen while a word is pending is remembered until the output empties.
    assign w_pad_go   = !r_full && (flush || r_flush_pend) &&
                        (r_state == ST_IDLE || r_state == ST_VALID);
    assign w_pad_load = w_in_pad && !r_full && (!r_out_valid || bus.out_ready) && !start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_flush_pend <= 1'b0;
        else if (start) r_flush_pend <= 1'b0;
        else            r_flush_pend <= w_pad_go;
    end
`else
    localparam state_t ST_PAD_TGT = ST_IDLE;
    logic w_unused_flush;

    assign w_unused_flush = flush;
    assign w_in_pad       = 1'b0;
    assign w_pad_go       = 1'b0;
    assign w_pad_load     = 1'b0;
`endif

    assign bus.in_ready = (!r_out_valid || bus.out_ready) && !r_full && !start && !w_in_pad;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_drain      = r_out_valid && bus.out_ready;
    assign w_load       = (w_accept && !w_bad) || w_pad_load;
    assign w_load_word  = w_pad_load ? NOP : w_word;
    assign w_addr       = BASE_ADDR + (32'(r_count) << 2);
    assign w_count_nx   = r_count + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= BASE_ADDR;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else if (start) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
            // A load also covers the drain of the previous word on the same edge.
            if (w_load) begin
                r_out_instr <= w_load_word;
                r_out_addr  <= w_addr;
                r_out_valid <= 1'b1;
                r_count     <= w_count_nx;
                r_full      <= (w_count_nx == CW'(DEPTH));
                if (!w_in_pad) r_state <= ST_VALID;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
                if (r_full) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end else if (w_in_pad || w_pad_go) begin
                    r_state <= ST_PAD_TGT;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else if (r_state == ST_IDLE && w_pad_go) begin
                r_state <= ST_PAD_TGT;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_out_addr;
    assign count         = r_count;
    assign full          = r_full;
    assign err           = r_err;
    assign done          = r_done;
endmodule

// File: tb/tb_insencoder.sv
// Self-checking bench for insencoder: directed scenarios plus a randomized run against a queue model.
module tb_insencoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [CW-1:0] count;
    logic full, err, done;
    int n_vec = 0, n_err = 0;

    insencoder_if bus ();

    insencoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .bus(bus),
        .count(count), .full(full), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    // Reference packing by field weights.
    function automatic logic [31:0] mpack(input int f, input int op, input int rs, input int rt,
                                          input int rd, input int sa, input int fn, input int imm,
                                          input int tgt);
        int unsigned w;
        w = 0;
        case (f)
            0: w = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sa * 64 + fn;
            1: w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
            2: w = op * 67108864 + tgt;
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic drive(input int f, input int op, input int rs, input int rt, input int rd,
                         input int sa, input int fn, input int imm, input int tgt);
        bus.in_valid  = 1'b1;
        bus.fmt       = f[1:0];
        bus.op        = op[5:0];
        bus.rs        = rs[4:0];
        bus.rt        = rt[4:0];
        bus.rd        = rd[4:0];
        bus.sa        = sa[4:0];
        bus.func      = fn[5:0];
        bus.immediate = imm[15:0];
        bus.target    = tgt[25:0];
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_vec++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr got=%h exp=0", bus.out_instr); end
        n_vec++; if (bus.out_addr !== BASE) begin n_err++; $display("FAIL rst_out_addr got=%h exp=%h", bus.out_addr, BASE); end
        n_vec++; if (count !== '0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_vec++; if ({full, err, done} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {full, err, done}); end
        reset = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_r_add();
        pulse_start();
        bus.out_ready = 1'b1;
        drive(0, 0, 1, 2, 3, 0, 'h20, 'hBEEF, 'h3FF);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL radd_valid got=%b exp=1", bus.out_valid); end
        n_vec++; if (bus.out_instr !== 32'h0022_1820) begin n_err++; $display("FAIL radd_instr got=%h exp=00221820", bus.out_instr); end
        n_vec++; if (bus.out_addr !== BASE) begin n_err++; $display("FAIL radd_addr got=%h exp=%h", bus.out_addr, BASE); end
        n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL radd_count got=%0d exp=1", count); end
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL radd_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        bus.out_ready = 1'b1;
        drive(1, 'h08, 0, 8, 0, 0, 0, 5, 0); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0 got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        drive(2, 2, 0, 0, 0, 0, 0, 0, 'h10); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got=%b exp=1", bus.in_ready); end
        n_vec++; if (bus.out_instr !== 32'h2008_0005 || bus.out_addr !== BASE)
            begin n_err++; $display("FAIL b2b_addi got=%h@%h exp=20080005@%h", bus.out_instr, bus.out_addr, BASE); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0800_0010 || bus.out_addr !== BASE + 4)
            begin n_err++; $display("FAIL b2b_j got=%b %h@%h exp=1 08000010@%h", bus.out_valid, bus.out_instr, bus.out_addr, BASE + 4); end
        n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", count); end
    endtask

    task automatic test_backpressure();
        pulse_start();
        bus.out_ready = 1'b0;
        drive(1, 'h23, 29, 8, 0, 0, 0, 4, 0);
        @(negedge clk);
        drive(1, 'h08, 0, 8, 0, 0, 0, 5, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus.in_ready); end
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h8FA8_0004 || bus.out_addr !== BASE)
                begin n_err++; $display("FAIL bp_hold[%0d] got=%b %h@%h exp=1 8fa80004@%h", i, bus.out_valid, bus.out_instr, bus.out_addr, BASE); end
            n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL bp_count[%0d] got=%0d exp=1", i, count); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0 || count !== CW'(1))
            begin n_err++; $display("FAIL bp_release got=%b/%0d exp=0/1", bus.out_valid, count); end
    endtask

    task automatic test_illegal();
        pulse_start();
        bus.out_ready = 1'b1;
        drive(0, 0, 1, 2, 3, 0, 'h20, 0, 0);
        @(negedge clk);
        drive(3, 'h3F, 31, 31, 31, 31, 'h3F, 'hFFFF, 'h3FFFFFF); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_err got=%b exp=1", err); end
        n_vec++; if (bus.out_valid !== 1'b0 || count !== CW'(1))
            begin n_err++; $display("FAIL ill_noout got=%b/%0d exp=0/1", bus.out_valid, count); end
        @(negedge clk);
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ill_errpulse got=%b exp=0", err); end
        drive(2, 2, 0, 0, 0, 0, 0, 0, 'h10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_addr !== BASE + 4)
            begin n_err++; $display("FAIL ill_nextaddr got=%b@%h exp=1@%h", bus.out_valid, bus.out_addr, BASE + 4); end
    endtask

    task automatic test_capacity();
        logic [31:0] w;
        pulse_start();
        bus.out_ready = 1'b1;
        w = 0;
        for (int k = 0; k < DEPTH; k++) begin
            int op, rs;
            op = $urandom_range(0, 63); rs = $urandom_range(0, 31);
            drive(1, op, rs, k, 0, 0, 0, 'h100 + k, 0);
            w = mpack(1, op, rs, k, 0, 0, 0, 'h100 + k, 0);
            #1;
            n_vec++; if (bus.in_ready !== 1'b1 || full !== 1'b0)
                begin n_err++; $display("FAIL cap_fill[%0d] got=%b/%b exp=1/0", k, bus.in_ready, full); end
            @(negedge clk);
        end
        n_vec++; if (full !== 1'b1 || count !== CW'(DEPTH) || bus.out_instr !== w || bus.out_addr !== BASE + 4 * (DEPTH - 1))
            begin n_err++; $display("FAIL cap_full got=%b/%0d %h@%h exp=1/%0d %h@%h", full, count, bus.out_instr, bus.out_addr, DEPTH, w, BASE + 4 * (DEPTH - 1)); end
        drive(0, 0, 1, 2, 3, 0, 'h20, 0, 0); #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL cap_stall got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || bus.out_valid !== 1'b0 || count !== CW'(DEPTH))
            begin n_err++; $display("FAIL cap_done got=%b/%b/%0d exp=1/0/%0d", done, bus.out_valid, count, DEPTH); end
        start = 1'b1; #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL cap_startready got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        start = 1'b0;
        n_vec++; if ({full, done} !== 2'b00 || count !== '0 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL cap_restart got=%b%b/%0d/%b exp=00/0/0", full, done, count, bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_addr !== BASE || bus.out_instr !== 32'h0022_1820)
            begin n_err++; $display("FAIL cap_reload got=%b %h@%h exp=1 00221820@%h", bus.out_valid, bus.out_instr, bus.out_addr, BASE); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] q_instr[$], q_addr[$];
        int  m_count, f, op, rs, rt, rd, sa, fn, imm, tgt;
        bit  m_err, do_start, exp_ready;
        m_count = 0; m_err = 0;
        pulse_start();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_vec++; if (bus.out_valid !== (q_instr.size() != 0))
                begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, bus.out_valid, q_instr.size() != 0); end
            if (q_instr.size() != 0) begin
                n_vec++; if (bus.out_instr !== q_instr[0] || bus.out_addr !== q_addr[0])
                    begin n_err++; $display("FAIL rnd_word[%0d] got=%h@%h exp=%h@%h", cyc, bus.out_instr, bus.out_addr, q_instr[0], q_addr[0]); end
            end
            n_vec++; if (count !== CW'(m_count) || full !== (m_count == DEPTH) || err !== m_err ||
                         done !== (m_count == DEPTH && q_instr.size() == 0))
                begin n_err++; $display("FAIL rnd_status[%0d] got=%0d/%b/%b/%b exp=%0d/%b/%b/%b", cyc, count, full, err, done,
                                        m_count, m_count == DEPTH, m_err, m_count == DEPTH && q_instr.size() == 0); end
            do_start = (m_count == DEPTH && q_instr.size() == 0) || ($urandom_range(0, 39) == 0);
            f = $urandom_range(0, 3); op = $urandom_range(0, 63); rs = $urandom_range(0, 31);
            rt = $urandom_range(0, 31); rd = $urandom_range(0, 31); sa = $urandom_range(0, 31);
            fn = $urandom_range(0, 63); imm = $urandom_range(0, 65535); tgt = $urandom_range(0, 67108863);
            drive(f, op, rs, rt, rd, sa, fn, imm, tgt);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            start = do_start;
            #1;
            exp_ready = !do_start && (q_instr.size() == 0 || bus.out_ready) && m_count < DEPTH;
            n_vec++; if (bus.in_ready !== exp_ready)
                begin n_err++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, bus.in_ready, exp_ready); end
            if (do_start) begin
                q_instr.delete(); q_addr.delete(); m_count = 0; m_err = 0;
            end else begin
                if (q_instr.size() != 0 && bus.out_ready) begin
                    void'(q_instr.pop_front()); void'(q_addr.pop_front());
                end
                m_err = 0;
                if (bus.in_valid && exp_ready) begin
                    if (f == 3) m_err = 1;
                    else begin
                        q_instr.push_back(mpack(f, op, rs, rt, rd, sa, fn, imm, tgt));
                        q_addr.push_back(BASE + 32'(4 * m_count));
                        m_count++;
                    end
                end
            end
            @(negedge clk);
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        bus.out_ready = 1'b0;
        drive(2, 2, 0, 0, 0, 0, 0, 0, 'h1234);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre got=%b exp=1", bus.out_valid); end
        reset = 1'b1; #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== BASE || count !== '0 || {full, err, done} !== 3'b000)
            begin n_err++; $display("FAIL rmid_async got=%b %h@%h %0d %b exp=0 0@%h 0 000", bus.out_valid, bus.out_instr, bus.out_addr, count, {full, err, done}, BASE); end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef INSENC_NOP_PAD_EN
    task automatic test_pad();
        int n;
        bit fin;
        n = 0; fin = 0;
        pulse_start();
        bus.out_ready = 1'b1;
        drive(0, 0, 1, 2, 3, 0, 'h20, 0, 0);
        @(negedge clk);
        drive(2, 2, 0, 0, 0, 0, 0, 0, 'h10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(0, 0, 1, 2, 3, 0, 'h20, 0, 0);
        for (int i = 0; i < 10 && !fin; i++) begin
            #1;
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL pad_ready[%0d] got=%b exp=0", i, bus.in_ready); end
            if (bus.out_valid) begin
                n_vec++; if (bus.out_instr !== 32'h0 || bus.out_addr !== BASE + 32'(8 + 4 * n))
                    begin n_err++; $display("FAIL pad_word[%0d] got=%h@%h exp=0@%h", n, bus.out_instr, bus.out_addr, BASE + 32'(8 + 4 * n)); end
                n++;
            end
            if (done) fin = 1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_vec++; if (!fin || n != 2 || count !== CW'(DEPTH))
            begin n_err++; $display("FAIL pad_end got=done%0d/%0d words/%0d exp=done1/2 words/%0d", fin, n, count, DEPTH); end
    endtask
`else
    task automatic test_flush_ignored();
        pulse_start();
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1, 'h08, 0, 8, 0, 0, 0, 5, 0); #1;
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || count !== '0)
            begin n_err++; $display("FAIL flush_ign got=%b/%b/%0d exp=1/0/0", bus.in_ready, bus.out_valid, count); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_instr !== 32'h2008_0005 || bus.out_addr !== BASE)
            begin n_err++; $display("FAIL flush_word got=%h@%h exp=20080005@%h", bus.out_instr, bus.out_addr, BASE); end
    endtask
`endif

    initial begin
        test_reset();
        test_r_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_capacity();
        test_random();
`ifdef INSENC_NOP_PAD_EN
        test_pad();
`else
        test_flush_ignored();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
